// File: rtl/sca_blk_wr_sched_pkg.sv
// sca_blk_wr_sched_pkg: FSM encoding, source indices and grant priority for the write-port scheduler
package sca_blk_wr_sched_pkg;
  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_WRITE, S_HOLD} st_t;
  localparam logic [1:0] SRC_A = 2'd0;
  localparam logic [1:0] SRC_B = 2'd1;
  localparam logic [1:0] SRC_C = 2'd2;
  localparam logic [1:0] SRC_D = 2'd3;
  localparam logic [1:0] PRIO [4] = '{SRC_A, SRC_C, SRC_B, SRC_D};
  typedef struct packed {
    st_t        st;
    logic [1:0] gnt;
    logic       pa;
    logic       pb;
    logic       pd;
  } ctl_t;
  function automatic logic [1:0] pick(input logic [3:0] req);
    pick = PRIO[3];
    for (int i = 3; i >= 0; i--)
      if (req[PRIO[i]]) pick = PRIO[i];
  endfunction
  function automatic ctl_t vote(input ctl_t a, input ctl_t b, input ctl_t c);
    return ctl_t'((a & b) | (a & c) | (b & c));
  endfunction
endpackage

// File: rtl/sca_blk_wr_sched_fifo.sv
// sca_rel_fifo: address FIFO for readout-done releases; simultaneous pop and push is allowed when full
module sca_rel_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       CLK,
  input  logic       lrst,
  input  logic       i_push,
  input  logic       i_pop,
  input  logic [3:0] i_din,
  output logic [3:0] o_dout,
  output logic       o_full,
  output logic       o_empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  logic [3:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0]   r_cnt;
  assign o_dout  = r_mem[r_rp];
  assign o_full  = r_cnt == (AW+1)'(DEPTH);
  assign o_empty = r_cnt == '0;
  always_ff @(posedge CLK)
    if (i_push) r_mem[r_wp] <= i_din;
  always_ff @(posedge CLK or posedge lrst)
    if (lrst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      r_wp  <= r_wp + AW'(i_push);
      r_rp  <= r_rp + AW'(i_pop);
      r_cnt <= r_cnt + (AW+1)'(i_push) - (AW+1)'(i_pop);
    end
endmodule

// File: rtl/sca_blk_wr_sched.sv
// sca_blk_wr_sched: arbitrates four block-release sources onto the next-block memory write port
module sca_blk_wr_sched
  import sca_blk_wr_sched_pkg::*;
#(
  parameter int TMR         = 0,
  parameter int CFIFO_DEPTH = 4,
  parameter int CNT_W       = 8
) (
  input  logic             CLK,
  input  logic             lrst,
  input  logic             ENAREG,
  input  logic             ALLOC_REQ,
  input  logic             NL1A_REQ,
  input  logic [3:0]       NL1A_IN,
  input  logic             YL1A_REQ,
  input  logic [3:0]       YL1A_IN,
  input  logic             FB_REQ,
  input  logic [3:0]       FB_IN,
  output logic             PATHASEL,
  output logic             PATHBSEL,
  output logic             PATHCSEL,
  output logic             PATHDSEL,
  output logic [3:0]       NL1A_ADR,
  output logic [3:0]       YL1A_ADR,
  output logic [3:0]       FB_ADR,
  output logic             NBSEL,
  output logic             WRENA,
  output logic             BUSY,
  output logic             DROP_ERR,
  output logic [CNT_W-1:0] WR_CNT,
  output logic [CNT_W-1:0] DROP_CNT
);
  localparam int N = (TMR != 0) ? 3 : 1;
  ctl_t           r_ctl [N];
  ctl_t           w_v, w_nx;
  logic [3:0]     r_b_adr, r_d_adr;
  logic [3:0]     w_req, w_free, w_drop, w_sel_nx, w_fifo_q;
  logic           w_full, w_empty, w_pend_a, w_pend_b, w_pend_d, w_push, w_grant;
  logic [CNT_W:0] w_drop_sum;
  generate
    if (N == 3) begin : g_tmr
      assign w_v = vote(r_ctl[0], r_ctl[1], r_ctl[2]);
    end else begin : g_one
      assign w_v = r_ctl[0];
    end
  endgenerate
  sca_rel_fifo #(.DEPTH(CFIFO_DEPTH)) u_cfifo (
    .CLK(CLK), .lrst(lrst), .i_push(w_push), .i_pop(w_free[SRC_C]), .i_din(YL1A_IN),
    .o_dout(w_fifo_q), .o_full(w_full), .o_empty(w_empty)
  );
  assign BUSY = w_v.pa | w_v.pb | w_v.pd | ~w_empty | (w_v.st != S_IDLE);
  // Slots free in WRITE before new requests are judged, so a same-cycle REQ is never dropped
  always_comb begin
    w_free     = (w_v.st == S_WRITE) ? 4'b0001 << w_v.gnt : 4'b0000;
    w_pend_a   = w_v.pa & ~w_free[SRC_A];
    w_pend_b   = w_v.pb & ~w_free[SRC_B];
    w_pend_d   = w_v.pd & ~w_free[SRC_D];
    w_drop     = {FB_REQ & w_pend_d, YL1A_REQ & w_full & ~w_free[SRC_C], NL1A_REQ & w_pend_b, ALLOC_REQ & w_pend_a};
    w_push     = YL1A_REQ & ~w_drop[SRC_C];
    w_req      = {w_v.pd | FB_REQ, ~w_empty | YL1A_REQ, w_v.pb | NL1A_REQ, w_v.pa | ALLOC_REQ};
    w_grant    = (w_v.st == S_IDLE) & (|w_req);
    w_nx.pa    = w_pend_a | ALLOC_REQ;
    w_nx.pb    = w_pend_b | NL1A_REQ;
    w_nx.pd    = w_pend_d | FB_REQ;
    w_nx.gnt   = (w_v.st == S_IDLE) ? pick(w_req) : w_v.gnt;
    w_nx.st    = (w_v.st == S_IDLE)  ? (w_grant ? S_SETUP : S_IDLE) :
                 (w_v.st == S_SETUP) ? (ENAREG ? S_SETUP : S_WRITE) :
                 (w_v.st == S_WRITE) ? S_HOLD : S_IDLE;
    w_sel_nx   = (w_nx.st == S_IDLE) ? 4'b0000 : 4'b0001 << w_nx.gnt;
    w_drop_sum = {1'b0, DROP_CNT} + (CNT_W+1)'($countones(w_drop));
  end
  always_ff @(posedge CLK or posedge lrst)
    if (lrst) begin
      for (int i = 0; i < N; i++) r_ctl[i] <= '0;
      {PATHDSEL, PATHCSEL, PATHBSEL, PATHASEL} <= '0;
      {NBSEL, WRENA, DROP_ERR} <= '0;
      {r_b_adr, r_d_adr, NL1A_ADR, YL1A_ADR, FB_ADR} <= '0;
      WR_CNT   <= '0;
      DROP_CNT <= '0;
    end else begin
      for (int i = 0; i < N; i++) r_ctl[i] <= w_nx;
      {PATHDSEL, PATHCSEL, PATHBSEL, PATHASEL} <= w_sel_nx;
      NBSEL    <= w_nx.st != S_IDLE;
      WRENA    <= w_nx.st == S_WRITE;
      DROP_ERR <= DROP_ERR | (|w_drop);
      DROP_CNT <= w_drop_sum[CNT_W] ? '1 : w_drop_sum[CNT_W-1:0];
      if (w_v.st == S_WRITE && !(&WR_CNT)) WR_CNT <= WR_CNT + CNT_W'(1);
      if (NL1A_REQ & ~w_pend_b) r_b_adr <= NL1A_IN;
      if (FB_REQ & ~w_pend_d) r_d_adr <= FB_IN;
      if (w_grant && w_nx.gnt == SRC_B) NL1A_ADR <= w_pend_b ? r_b_adr : NL1A_IN;
      if (w_grant && w_nx.gnt == SRC_C) YL1A_ADR <= w_empty ? YL1A_IN : w_fifo_q;
      if (w_grant && w_nx.gnt == SRC_D) FB_ADR <= w_pend_d ? r_d_adr : FB_IN;
    end
endmodule

// File: tb/tb_sca_blk_wr_sched.sv
// tb_sca_blk_wr_sched: directed scenarios plus random traffic against a queue-based model of the scheduler
module tb_sca_blk_wr_sched;
  localparam int DEPTH = 4;
  localparam int CW = 8;
  localparam int MAXC = (1 << CW) - 1;
  logic CLK = 0, lrst = 1, ENAREG = 0;
  logic ALLOC_REQ = 0, NL1A_REQ = 0, YL1A_REQ = 0, FB_REQ = 0;
  logic [3:0] NL1A_IN = 0, YL1A_IN = 0, FB_IN = 0;
  logic PATHASEL, PATHBSEL, PATHCSEL, PATHDSEL, NBSEL, WRENA, BUSY, DROP_ERR;
  logic [3:0] NL1A_ADR, YL1A_ADR, FB_ADR;
  logic [CW-1:0] WR_CNT, DROP_CNT;
  int total = 0, bad = 0, cy = 0;

  always #5 CLK = ~CLK;

  sca_blk_wr_sched #(.TMR(1), .CFIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .CLK(CLK), .lrst(lrst), .ENAREG(ENAREG),
    .ALLOC_REQ(ALLOC_REQ), .NL1A_REQ(NL1A_REQ), .NL1A_IN(NL1A_IN),
    .YL1A_REQ(YL1A_REQ), .YL1A_IN(YL1A_IN), .FB_REQ(FB_REQ), .FB_IN(FB_IN),
    .PATHASEL(PATHASEL), .PATHBSEL(PATHBSEL), .PATHCSEL(PATHCSEL), .PATHDSEL(PATHDSEL),
    .NL1A_ADR(NL1A_ADR), .YL1A_ADR(YL1A_ADR), .FB_ADR(FB_ADR),
    .NBSEL(NBSEL), .WRENA(WRENA), .BUSY(BUSY), .DROP_ERR(DROP_ERR),
    .WR_CNT(WR_CNT), .DROP_CNT(DROP_CNT)
  );

  // Model: per-source pending slots and a C queue; one transaction walks setup(1) -> write(2) -> hold(3)
  bit m_pa, m_pb, m_pd, m_act, m_derr, m_idle;
  logic [3:0] m_badr, m_dadr;
  logic [3:0] m_adr [4];
  logic [3:0] m_cq [$];
  int m_src, m_stage, m_wr, m_drop;

  function automatic int sat(input int v);
    return v > MAXC ? MAXC : v;
  endfunction

  always @(posedge CLK or posedge lrst) begin
    if (lrst) begin
      {m_pa, m_pb, m_pd, m_act, m_derr} = '0;
      m_badr = 0; m_dadr = 0;
      for (int i = 0; i < 4; i++) m_adr[i] = 0;
      m_cq.delete();
      m_src = 0; m_stage = 0; m_wr = 0; m_drop = 0;
    end else begin
      m_idle = !m_act;
      if (m_act && m_stage == 2) begin
        m_wr = sat(m_wr + 1);
        if (m_src == 0) m_pa = 0;
        if (m_src == 1) m_pb = 0;
        if (m_src == 2) void'(m_cq.pop_front());
        if (m_src == 3) m_pd = 0;
      end
      if (ALLOC_REQ) begin
        if (m_pa) begin m_drop = sat(m_drop + 1); m_derr = 1; end
        else m_pa = 1;
      end
      if (NL1A_REQ) begin
        if (m_pb) begin m_drop = sat(m_drop + 1); m_derr = 1; end
        else begin m_pb = 1; m_badr = NL1A_IN; end
      end
      if (YL1A_REQ) begin
        if (m_cq.size() == DEPTH) begin m_drop = sat(m_drop + 1); m_derr = 1; end
        else m_cq.push_back(YL1A_IN);
      end
      if (FB_REQ) begin
        if (m_pd) begin m_drop = sat(m_drop + 1); m_derr = 1; end
        else begin m_pd = 1; m_dadr = FB_IN; end
      end
      if (m_idle) begin
        m_src = m_pa ? 0 : (m_cq.size() > 0) ? 2 : m_pb ? 1 : m_pd ? 3 : -1;
        if (m_src >= 0) begin
          m_act = 1; m_stage = 1;
          if (m_src == 1) m_adr[1] = m_badr;
          if (m_src == 2) m_adr[2] = m_cq[0];
          if (m_src == 3) m_adr[3] = m_dadr;
        end
      end else if (m_stage == 1) begin
        if (!ENAREG) m_stage = 2;
      end else if (m_stage == 2) m_stage = 3;
      else m_act = 0;
    end
  end

  typedef struct { int c; logic [3:0] sel; logic [3:0] adr; } wr_t;
  wr_t wlog [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cy);
    end
  endtask

  task automatic cmp_model();
    logic [3:0] sel;
    sel = m_act ? 4'b0001 << m_src : 4'b0000;
    chk("sel", {28'd0, PATHDSEL, PATHCSEL, PATHBSEL, PATHASEL}, {28'd0, sel});
    chk("nbsel", {31'd0, NBSEL}, {31'd0, m_act});
    chk("wrena", {31'd0, WRENA}, {31'd0, m_act && m_stage == 2});
    chk("busy", {31'd0, BUSY}, {31'd0, m_pa | m_pb | m_pd | m_act | (m_cq.size() > 0)});
    chk("drop_err", {31'd0, DROP_ERR}, {31'd0, m_derr});
    chk("nl1a_adr", {28'd0, NL1A_ADR}, {28'd0, m_adr[1]});
    chk("yl1a_adr", {28'd0, YL1A_ADR}, {28'd0, m_adr[2]});
    chk("fb_adr", {28'd0, FB_ADR}, {28'd0, m_adr[3]});
    chk("wr_cnt", 32'(WR_CNT), 32'(m_wr));
    chk("drop_cnt", 32'(DROP_CNT), 32'(m_drop));
  endtask

  task automatic cyc();
    wr_t w;
    @(posedge CLK);
    @(negedge CLK);
    cy++;
    cmp_model();
    if (WRENA) begin
      w.c = cy;
      w.sel = {PATHDSEL, PATHCSEL, PATHBSEL, PATHASEL};
      w.adr = PATHBSEL ? NL1A_ADR : PATHCSEL ? YL1A_ADR : PATHDSEL ? FB_ADR : 4'h0;
      wlog.push_back(w);
    end
    {ALLOC_REQ, NL1A_REQ, YL1A_REQ, FB_REQ} = '0;
  endtask

  initial begin
    int n;
    logic [3:0] es [4];
    logic [3:0] ea [4];
    repeat (2) @(negedge CLK);
    chk("rst ctl", {24'd0, PATHASEL, PATHBSEL, PATHCSEL, PATHDSEL, NBSEL, WRENA, BUSY, DROP_ERR}, 0);
    chk("rst adr", {20'd0, NL1A_ADR, YL1A_ADR, FB_ADR}, 0);
    chk("rst cnt", {16'd0, WR_CNT, DROP_CNT}, 0);
    lrst = 0;
    cyc();
    // single B release
    n = cy; NL1A_IN = 4'h9; NL1A_REQ = 1;
    cyc();
    chk("t1 setup sel", {31'd0, PATHBSEL}, 1);
    chk("t1 setup adr", {28'd0, NL1A_ADR}, 9);
    chk("t1 setup wrena", {31'd0, WRENA}, 0);
    cyc();
    chk("t1 write wrena", {31'd0, WRENA}, 1);
    cyc();
    chk("t1 hold", {30'd0, PATHBSEL, WRENA}, 2);
    cyc();
    chk("t1 idle", {30'd0, PATHBSEL, NBSEL}, 0);
    chk("t1 wr_cnt", 32'(WR_CNT), 1);
    // all four sources at once
    wlog.delete(); n = cy;
    ALLOC_REQ = 1; YL1A_REQ = 1; YL1A_IN = 4'h5; NL1A_REQ = 1; NL1A_IN = 4'h2; FB_REQ = 1; FB_IN = 4'hC;
    repeat (16) cyc();
    es = '{4'b0001, 4'b0100, 4'b0010, 4'b1000};
    ea = '{4'h0, 4'h5, 4'h2, 4'hC};
    chk("t2 writes", wlog.size(), 4);
    for (int i = 0; i < 4 && i < wlog.size(); i++) begin
      chk("t2 cycle", wlog[i].c, n + 2 + 4 * i);
      chk("t2 path", {28'd0, wlog[i].sel}, {28'd0, es[i]});
      chk("t2 adr", {28'd0, wlog[i].adr}, {28'd0, ea[i]});
    end
    chk("t2 drops", 32'(DROP_CNT), 0);
    // five C pulses while ENAREG stalls the first write: fifth overflows
    wlog.delete(); ENAREG = 1;
    for (int i = 0; i < 5; i++) begin
      YL1A_IN = 4'(i + 1); YL1A_REQ = 1;
      cyc();
    end
    ENAREG = 0;
    repeat (20) cyc();
    chk("t3 writes", wlog.size(), 4);
    for (int i = 0; i < 4 && i < wlog.size(); i++) begin
      chk("t3 path", {28'd0, wlog[i].sel}, 4);
      chk("t3 adr", {28'd0, wlog[i].adr}, i + 1);
    end
    chk("t3 drop_err", {31'd0, DROP_ERR}, 1);
    chk("t3 drop_cnt", 32'(DROP_CNT), 1);
    // ENAREG high for three cycles from SETUP
    n = cy; NL1A_IN = 4'h6; NL1A_REQ = 1;
    cyc();
    ENAREG = 1;
    for (int i = 0; i < 3; i++) begin
      chk("t4 stall", {30'd0, NBSEL, WRENA}, 2);
      cyc();
      chk("t4 overlap", {31'd0, WRENA & ENAREG}, 0);
    end
    ENAREG = 0;
    chk("t4 last setup", {30'd0, NBSEL, WRENA}, 2);
    cyc();
    chk("t4 write", {31'd0, WRENA}, 1);
    chk("t4 write cycle", cy, n + 5);
    repeat (3) cyc();
    // reset during WRITE
    lrst = 1; @(negedge CLK); lrst = 0;
    n = cy; NL1A_IN = 4'h4; NL1A_REQ = 1;
    cyc(); cyc();
    chk("t5 in write", {31'd0, WRENA}, 1);
    #2 lrst = 1;
    #1;
    chk("t5 async drop", {28'd0, WRENA, NBSEL, PATHBSEL, BUSY}, 0);
    chk("t5 wr_cnt", 32'(WR_CNT), 0);
    @(negedge CLK); lrst = 0;
    cyc(); cyc();
    chk("t5 idle", {30'd0, BUSY, NBSEL}, 0);
    chk("t5 wr_cnt after", 32'(WR_CNT), 0);
    // second B request in the WRITE cycle of the first
    wlog.delete(); n = cy; NL1A_IN = 4'h3; NL1A_REQ = 1;
    cyc(); cyc();
    NL1A_IN = 4'h7; NL1A_REQ = 1;
    repeat (8) cyc();
    chk("t6 writes", wlog.size(), 2);
    if (wlog.size() == 2) begin
      chk("t6 first", wlog[0].c, n + 2);
      chk("t6 second", wlog[1].c, n + 6);
      chk("t6 adr2", {28'd0, wlog[1].adr}, 7);
    end
    chk("t6 no drop", 32'(DROP_CNT), 0);
    // dense random traffic, long enough to saturate both counters
    repeat (4000) begin
      ALLOC_REQ = $urandom_range(0, 3) == 0;
      NL1A_REQ = $urandom_range(0, 3) == 0;
      YL1A_REQ = $urandom_range(0, 2) == 0;
      FB_REQ = $urandom_range(0, 3) == 0;
      NL1A_IN = 4'($urandom); YL1A_IN = 4'($urandom); FB_IN = 4'($urandom);
      ENAREG = $urandom_range(0, 3) == 0;
      cyc();
    end
    ENAREG = 0;
    repeat (40) cyc();
    chk("sat wr_cnt", 32'(WR_CNT), MAXC);
    chk("sat drop_cnt", 32'(DROP_CNT), MAXC);
    chk("drained", {31'd0, BUSY}, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
